// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//   Multi-cycle ripple-borrow subtractor. Resolves BITS_PER_CYCLE bits of
//   A - B per clock, LSB first, and returns {borrow_out, (A-B) mod 2^WIDTH}.
//   With A = adder sum and B = one addend, the difference is the other addend.
//   Valid/ready handshake on both the operand and the result side.
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     operand handshake (accepted only in IDLE)
//   i_minuend, i_subtrahend  operands A, B (captured at acceptance)
//   o_valid / i_ready     result handshake (o_result held while i_ready=0)
//   o_result              [WIDTH-1:0] difference, [WIDTH] borrow out (A<B)
//   o_busy                high while bits are being resolved
module serial_ripple_subtractor #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_busy
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_param
      $error("serial_ripple_subtractor: WIDTH must be a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        a_sh, b_sh, diff, diff_nxt;
  logic                    borrow;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH:0]          result;
  logic [BITS_PER_CYCLE:0] step;
  logic                    last;

  // One chunk of the ripple: the extra top bit of the (BITS_PER_CYCLE+1)-bit
  // difference is the borrow into the next chunk.
  assign step = {1'b0, a_sh[BITS_PER_CYCLE-1:0]}
              - {1'b0, b_sh[BITS_PER_CYCLE-1:0]}
              - {{BITS_PER_CYCLE{1'b0}}, borrow};

  // Difference chunks enter at the MSB end so after STEPS shifts chunk 0
  // sits at the LSB.
  generate
    if (BITS_PER_CYCLE == WIDTH) begin : g_diff_full
      assign diff_nxt = step[BITS_PER_CYCLE-1:0];
    end else begin : g_diff_shift
      assign diff_nxt = {step[BITS_PER_CYCLE-1:0], diff[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  assign last = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = RUN;
      RUN:     if (last)    state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a_sh   <= i_minuend;
          b_sh   <= i_subtrahend;
          borrow <= 1'b0;
          cnt    <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> BITS_PER_CYCLE;
          b_sh   <= b_sh >> BITS_PER_CYCLE;
          diff   <= diff_nxt;
          borrow <= step[BITS_PER_CYCLE];
          cnt    <= cnt + 1'b1;
          // Separate result register keeps o_result frozen outside DONE.
          if (last) result <= {step[BITS_PER_CYCLE], diff_nxt};
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_busy   = (state == RUN);
  assign o_valid  = (state == DONE);
  assign o_result = result;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;

  localparam int NB = 4;

  logic                    clk = 1'b0;
  logic                    rst, i_valid, i_ready;
  logic [15:0]             a, b;
  logic [NB-1:0]           rdy, vld, busy;
  logic [NB-1:0][16:0]     res;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Same stimulus to four instances with different chunk sizes.
  for (genvar g = 0; g < NB; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    serial_ripple_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(BPC)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy[g]),
      .i_minuend(a), .i_subtrahend(b), .o_valid(vld[g]), .i_ready(i_ready),
      .o_result(res[g]), .o_busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 17-bit two's-complement subtraction; bit 16 is the borrow.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Issue one operation, wait for all instances, hold i_ready low for `hold`
  // cycles (optionally with a competing i_valid), then release.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input int hold,
                        input bit chk_lat, input bit poke_valid,
                        output logic [NB-1:0][16:0] got);
    logic [16:0] exp;
    int cyc;
    exp = model(ta, tb_);
    @(negedge clk);
    a = ta; b = tb_; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);   // capture must already be done
    cyc = 0;
    while (!vld[0] && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (chk_lat) chk("latency", cyc, 16);
    cyc = 0;
    while (vld != '1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (vld != '1) chk("timeout", vld, {NB{1'b1}});
    for (int g = 0; g < NB; g++) got[g] = res[g];
    if (poke_valid) i_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_vld",  vld,  {NB{1'b1}});
      chk("hold_rdy",  rdy,  '0);
      chk("hold_busy", busy, '0);
      for (int g = 0; g < NB; g++) chk("hold_res", res[g], exp);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("release_vld", vld, '0);
    chk("release_rdy", rdy, {NB{1'b1}});
  endtask

  initial begin
    logic [NB-1:0][16:0] got;
    logic [15:0] x, y;
    logic [16:0] sum;
    int seen;

    rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0; a = 16'h1234; b = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  vld,  '0);
    chk("rst_busy", busy, '0);
    for (int g = 0; g < NB; g++) chk("rst_res", res[g], 0);
    i_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy", rdy, {NB{1'b1}});

    run_op(16'h1234, 16'h0034, 3, 1'b1, 1'b0, got);
    for (int g = 0; g < NB; g++) chk("basic", got[g], 17'h01200);

    run_op(16'h0000, 16'h0001, 0, 1'b1, 1'b0, got);
    for (int g = 0; g < NB; g++) chk("zero_minus_one", got[g], 17'h1FFFF);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0, got);
    for (int g = 0; g < NB; g++) chk("equal", got[g], 17'h00000);
    run_op(16'h0000, 16'h0000, 0, 1'b0, 1'b0, got);
    for (int g = 0; g < NB; g++) chk("zeros", got[g], 17'h00000);

    // Backpressure with a second request arriving while DONE.
    run_op(16'hBEEF, 16'h1111, 10, 1'b0, 1'b1, got);
    for (int g = 0; g < NB; g++) chk("bp_res", got[g], model(16'hBEEF, 16'h1111));
    @(posedge clk); #1;
    chk("bp_no_accept", busy, '0);

    // Abort in RUN cycle 7: the BPC=1 instance is still running.
    @(negedge clk);
    a = 16'h7777; b = 16'h1234; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort_busy_pre", busy[0], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, '0);
    chk("abort_rdy",  rdy,  {NB{1'b1}});
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (vld != '0) seen++; end
    chk("abort_no_valid", seen, 0);
    run_op(16'd5, 16'd3, 0, 1'b1, 1'b0, got);
    for (int g = 0; g < NB; g++) chk("after_abort", got[g], 17'h00002);

    // Inverse of the adder: A = x+y, B = y gives x back; borrow equals the carry.
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      if (i % 10 == 0) y = 16'($urandom_range(0, 3));
      sum = {1'b0, x} + {1'b0, y};
      run_op(sum[15:0], y, 0, 1'b0, 1'b0, got);
      for (int g = 0; g < NB; g++) begin
        chk("inv_diff",   got[g][15:0], x);
        chk("inv_borrow", got[g][16],   sum[16]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
